// File: rtl/univ_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_register
// Brief    : Universal shift register with manual ops and counted burst shifts
// Revision : 1.0 - initial release
// ============================================================================
module univ_shift_register #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             si_lsb,
  input  logic             si_msb,
  input  logic [WIDTH-1:0] pdata_in,
  input  logic             start,
  input  logic             dir,
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] pdata_out,
  output logic             so_msb,
  output logic             so_lsb,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0]    MODE_HOLD  = 2'b00;
  localparam logic [1:0]    MODE_LEFT  = 2'b01;
  localparam logic [1:0]    MODE_RIGHT = 2'b10;
  localparam logic [1:0]    MODE_LOAD  = 2'b11;
  localparam logic [CW-1:0] MAX_COUNT  = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_COUNT  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic             dir_q, dir_d;

  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] shr_val;
  logic [CW-1:0]    count_clamped;

  assign shl_val       = {sr_q[WIDTH-2:0], si_lsb};
  assign shr_val       = {si_msb, sr_q[WIDTH-1:1]};
  assign count_clamped = (count > MAX_COUNT) ? MAX_COUNT : count;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Register is left untouched on the capture edge; shifting starts next edge.
          dir_d   = dir;
          rem_d   = count_clamped;
          state_d = (count_clamped == '0) ? DONE : SHIFT;
        end else if (en) begin
          case (mode)
            MODE_LEFT:  sr_d = shl_val;
            MODE_RIGHT: sr_d = shr_val;
            MODE_LOAD:  sr_d = pdata_in;
            MODE_HOLD:  sr_d = sr_q;
            default:    sr_d = sr_q;
          endcase
        end
      end
      SHIFT: begin
        sr_d  = dir_q ? shr_val : shl_val;
        rem_d = rem_q - ONE_COUNT;
        if (rem_q == ONE_COUNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  assign pdata_out = sr_q;
  assign so_msb    = sr_q[WIDTH-1];
  assign so_lsb    = sr_q[0];
  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_univ_shift_register
// Brief    : Directed self-checking bench for univ_shift_register (WIDTH=8)
// Revision : 1.0 - initial release
// ============================================================================
module tb_univ_shift_register;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             reset_n;
  logic             en;
  logic [1:0]       mode;
  logic             si_lsb;
  logic             si_msb;
  logic [WIDTH-1:0] pdata_in;
  logic             start;
  logic             dir;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] pdata_out;
  logic             so_msb;
  logic             so_lsb;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  univ_shift_register #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .mode      (mode),
    .si_lsb    (si_lsb),
    .si_msb    (si_msb),
    .pdata_in  (pdata_in),
    .start     (start),
    .dir       (dir),
    .count     (count),
    .pdata_out (pdata_out),
    .so_msb    (so_msb),
    .so_lsb    (so_lsb),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One active edge, then settle 1ns so sampling is away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    en       = 1'b0;
    mode     = 2'b00;
    si_lsb   = 1'b0;
    si_msb   = 1'b0;
    pdata_in = '0;
    start    = 1'b0;
    dir      = 1'b0;
    count    = '0;

    step();
    chk("rst_pdata", pdata_out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_so", {so_msb, so_lsb}, 2'b00);
    #2 reset_n = 1'b1;

    // Parallel load
    en = 1'b1; mode = 2'b11; pdata_in = 8'hA5;
    step();
    chk("load_a5", pdata_out, 8'hA5);
    chk("load_so", {so_msb, so_lsb}, 2'b11);

    // Manual shift right, then hold with en low
    mode = 2'b10; si_msb = 1'b1;
    step(); chk("shr_1", pdata_out, 8'hD2);
    step(); chk("shr_2", pdata_out, 8'hE9);
    step(); chk("shr_3", pdata_out, 8'hF4);
    step(); chk("shr_4", pdata_out, 8'hFA);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("hold_en0", pdata_out, 8'hFA);
    end

    // Burst left by 3 from 8'h81
    en = 1'b1; mode = 2'b11; pdata_in = 8'h81;
    step(); chk("load_81", pdata_out, 8'h81);
    en = 1'b0; start = 1'b1; dir = 1'b0; count = 4'd3; si_lsb = 1'b1;
    step();
    chk("bl_k_pdata", pdata_out, 8'h81);
    chk("bl_k_busy", busy, 1'b1);
    start = 1'b0;
    step(); chk("bl_1", {busy, done, pdata_out}, {2'b10, 8'h03});
    step(); chk("bl_2", {busy, done, pdata_out}, {2'b10, 8'h07});
    step(); chk("bl_3", {busy, done, pdata_out}, {2'b01, 8'h0F});
    step(); chk("bl_after", {busy, done, pdata_out}, {2'b00, 8'h0F});

    // count = 0: straight to DONE, no shift
    start = 1'b1; count = 4'd0;
    step(); chk("c0_done", {busy, done, pdata_out}, {2'b01, 8'h0F});
    start = 1'b0;
    step(); chk("c0_after", {busy, done, pdata_out}, {2'b00, 8'h0F});

    // count = 15 clamps to 8 right shifts
    en = 1'b1; mode = 2'b11; pdata_in = 8'hFF;
    step(); chk("load_ff", pdata_out, 8'hFF);
    en = 1'b0; start = 1'b1; dir = 1'b1; count = 4'd15; si_msb = 1'b0;
    step(); chk("c15_k_busy", busy, 1'b1);
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 4) chk("c15_mid", pdata_out, 8'h0F);
      if (i < 8) chk("c15_busy", {busy, done}, 2'b10);
      else       chk("c15_end", {busy, done, pdata_out}, {2'b01, 8'h00});
    end
    step(); chk("c15_after", {busy, done}, 2'b00);

    // Start and load requested while busy must be ignored
    en = 1'b1; mode = 2'b11; pdata_in = 8'h3C;
    step(); chk("load_3c", pdata_out, 8'h3C);
    en = 1'b0; start = 1'b1; dir = 1'b0; count = 4'd2; si_lsb = 1'b0;
    step(); chk("ig_k", {busy, pdata_out}, {1'b1, 8'h3C});
    en = 1'b1; mode = 2'b11; pdata_in = 8'hFF; dir = 1'b1; count = 4'd5;
    step(); chk("ig_1", {busy, done, pdata_out}, {2'b10, 8'h78});
    step(); chk("ig_2", {busy, done, pdata_out}, {2'b01, 8'hF0});
    step(); chk("ig_idle", {busy, done, pdata_out}, {2'b00, 8'hF0});
    start = 1'b0; en = 1'b0;
    step(); chk("ig_noq", {busy, done, pdata_out}, {2'b00, 8'hF0});

    // Asynchronous reset mid-burst
    en = 1'b1; mode = 2'b11; pdata_in = 8'h55;
    step(); chk("load_55", pdata_out, 8'h55);
    en = 1'b0; start = 1'b1; dir = 1'b1; count = 4'd6; si_msb = 1'b1;
    step();
    start = 1'b0;
    step(); chk("ar_pre", {busy, pdata_out}, {1'b1, 8'hAA});
    #3 reset_n = 1'b0;
    #1 chk("ar_now", {busy, done, so_msb, so_lsb, pdata_out}, {4'b0000, 8'h00});
    step(); chk("ar_held", {busy, done, pdata_out}, {2'b00, 8'h00});
    #2 reset_n = 1'b1;
    step(); chk("ar_nodone", {busy, done, pdata_out}, {2'b00, 8'h00});
    en = 1'b1; mode = 2'b01; si_lsb = 1'b1;
    step(); chk("ar_manual", {busy, done, pdata_out}, {2'b00, 8'h01});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/univ_shift_register.md
UNIV_SHIFT_REGISTER -- requirements
Module: univ_shift_register

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 SHALL derive localparam CW = $clog2(WIDTH+1), the burst count field width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  in  1  enables manual mode operation this cycle.
REQ-006 SHALL have port mode  in  2  manual op select: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
REQ-007 SHALL have port si_lsb  in  1  serial bit entering bit 0 on a left shift.
REQ-008 SHALL have port si_msb  in  1  serial bit entering bit WIDTH-1 on a right shift.
REQ-009 SHALL have port pdata_in  in  WIDTH  parallel load data.
REQ-010 SHALL have port start  in  1  burst request, sampled in IDLE only.
REQ-011 SHALL have port dir  in  1  burst direction, captured with start: 0 left, 1 right.
REQ-012 SHALL have port count  in  CW  burst shift count, captured with start.
REQ-013 SHALL have port pdata_out  out  WIDTH  current register contents.
REQ-014 SHALL have port so_msb  out  1  register bit WIDTH-1.
REQ-015 SHALL have port so_lsb  out  1  register bit 0.
REQ-016 SHALL have port busy  out  1  high while in state SHIFT.
REQ-017 SHALL have port done  out  1  one-cycle pulse in state DONE.

Function
REQ-018 SHALL implement the FSM states IDLE, SHIFT and DONE; busy and done are decoded from state (registered, no combinational path from inputs).
REQ-019 Shift-left SHALL be reg <= {reg[WIDTH-2:0], si_lsb}; shift-right SHALL be reg <= {si_msb, reg[WIDTH-1:1]}; load SHALL be reg <= pdata_in.
REQ-020 In IDLE, with start=0 and en=1, the register SHALL perform the op selected by mode at the next edge; with en=0 or mode=00 it SHALL hold.
REQ-021 In IDLE with start=1, the block SHALL ignore en and mode, capture dir and count, leave the register unchanged that edge, and transition as follows:
  - count=0: go to DONE.
  - otherwise: go to SHIFT.
REQ-022 A captured count greater than WIDTH SHALL be clamped to WIDTH.
REQ-023 In SHIFT, the block SHALL perform one shift per edge in the captured direction using si_lsb/si_msb, and decrement the remaining count.
REQ-024 In SHIFT, the block SHALL go to DONE on the edge that performs the last shift; N shifts therefore occur on edges k+1..k+N after the start edge k, and done is high in the cycle after edge k+N.
REQ-025 In SHIFT and DONE, start, en and mode SHALL be ignored; start SHALL NOT be queued.
REQ-026 In DONE, the register SHALL hold, and the FSM SHALL return to IDLE unconditionally on the next edge.
REQ-027 pdata_out, so_msb and so_lsb SHALL reflect the register continuously; serial outputs SHALL change only at clock edges.

Reset
REQ-028 While reset_n=0, regardless of clk: the register SHALL be 0, state IDLE, remaining count 0, busy=0, done=0, so_msb=so_lsb=0.
REQ-029 Assertion of reset_n mid-burst SHALL abort the burst immediately, with no done pulse.
REQ-030 After reset_n deasserts, the first active edge SHALL obey IDLE rules.

Verification
REQ-031 Reset, load: WIDTH=8, mode=11, pdata_in=8'hA5, en=1 for one edge -> pdata_out=8'hA5, so_msb=1, so_lsb=1.
REQ-032 Manual shift-right: from 8'hA5, mode=10, si_msb=1, en=1 for 4 edges -> 8'hFA; then en=0 for 3 edges -> stays 8'hFA.
REQ-033 Burst: from 8'h81, start=1, dir=0, count=3, si_lsb=1 -> busy high for 3 cycles, pdata_out=8'h0F, done high for exactly one cycle, in the cycle after edge k+3.
REQ-034 Count boundary cases:
  - count=0 -> no shift, done in the cycle after the start edge.
  - count=15, si_msb=0 -> clamps to 8 right shifts; pdata_out=8'h00; done after edge k+8.
REQ-035 Start pulsed while busy; mode=11 during the burst -> no effect on the count or the register; exactly one done pulse.
REQ-036 reset_n pulsed low mid-burst, asynchronous to clk -> pdata_out=0 and busy=0 immediately; no done pulse; IDLE manual ops work on the next edge.
